bit_serializer_tx: RTL and testbench

- Parallel-to-serial stage that sits directly upstream of the serial pattern-detector FSMs.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on x.
- Includes a one-word holding buffer so back-to-back words stream with no idle gap.
- Drives framing flags so downstream detectors and benches can align to word boundaries.

---
 rtl/bit_serializer_tx.sv | 154 +++++++++++++++
 tb/tb_bit_serializer_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer_tx.sv
// Parallel-to-serial transmitter: accepts WIDTH-bit words over valid/ready and shifts
// them out one bit per clock, with a one-word holding buffer for gap-free streaming.
module bit_serializer_tx #(
   parameter int   WIDTH     = 8,
   parameter int   MSB_FIRST = 1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x,
   output logic             x_valid,
   output logic             frame_start,
   output logic             last_bit,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic             x_q, x_d;
   logic             x_valid_q, x_valid_d;
   logic             fs_q, fs_d;
   logic             lb_q, lb_d;
   logic             accept_s;
   logic             load_s;
   logic [WIDTH-1:0] load_word_s;

   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      if (MSB_FIRST != 0) begin
         return w[WIDTH-1];
      end else begin
         return w[0];
      end
   endfunction

   function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
      if (MSB_FIRST != 0) begin
         return {w[WIDTH-2:0], 1'b0};
      end else begin
         return {1'b0, w[WIDTH-1:1]};
      end
   endfunction

   assign din_ready   = !hold_full_q && !rst;
   assign accept_s    = din_valid && din_ready;
   assign x           = x_q;
   assign x_valid     = x_valid_q;
   assign frame_start = fs_q;
   assign last_bit    = lb_q;
   assign busy        = (state_q == ST_SHIFT) || hold_full_q;

   // Next-state: shift, buffer fill/drain, and loading of the next word into the shifter
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      x_d         = IDLE_BIT;
      x_valid_d   = 1'b0;
      fs_d        = 1'b0;
      lb_d        = 1'b0;
      load_s      = 1'b0;
      load_word_s = din;

      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               load_s = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (cnt_q != LAST_CNT) begin
               cnt_d     = cnt_q + CW'(1);
               x_d       = first_bit(shift_q);
               shift_d   = shift_word(shift_q);
               x_valid_d = 1'b1;
               lb_d      = (cnt_d == LAST_CNT);
               if (accept_s) begin
                  hold_d      = din;
                  hold_full_d = 1'b1;
               end else begin
                  hold_full_d = hold_full_q;
               end
            end else if (hold_full_q) begin
               // buffered word has priority; din_ready was low so no accept can collide
               load_s      = 1'b1;
               load_word_s = hold_q;
               hold_full_d = 1'b0;
            end else if (accept_s) begin
               load_s = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (load_s) begin
         state_d   = ST_SHIFT;
         cnt_d     = '0;
         x_d       = first_bit(load_word_s);
         shift_d   = shift_word(load_word_s);
         x_valid_d = 1'b1;
         fs_d      = 1'b1;
         lb_d      = 1'b0;
      end else begin
         fs_d = 1'b0;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         cnt_q       <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         x_q         <= IDLE_BIT;
         x_valid_q   <= 1'b0;
         fs_q        <= 1'b0;
         lb_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         x_q         <= x_d;
         x_valid_q   <= x_valid_d;
         fs_q        <= fs_d;
         lb_q        <= lb_d;
      end
   end

endmodule

// File: tb/tb_bit_serializer_tx.sv
// Self-checking bench for bit_serializer_tx: a bit-queue model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_bit_serializer_tx;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic [W-1:0] din;
   logic         din_valid;
   logic         din_ready, x, x_valid, frame_start, last_bit, busy;
   logic [W-1:0] din2;
   logic         din2_valid;
   logic         din2_ready, x2, x2_valid, fs2, lb2, busy2;

   int n_checks = 0;
   int n_errors = 0;

   bit_serializer_tx #(.WIDTH(W), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u_msb (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .x(x), .x_valid(x_valid), .frame_start(frame_start), .last_bit(last_bit), .busy(busy)
   );

   bit_serializer_tx #(.WIDTH(W), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .din(din2), .din_valid(din2_valid), .din_ready(din2_ready),
      .x(x2), .x_valid(x2_valid), .frame_start(fs2), .last_bit(lb2), .busy(busy2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the serial stream is a queue of pending bits; one bit leaves per edge.
   typedef struct packed { logic b; logic fs; logic lb; } mbit_t;
   mbit_t mq[$];
   logic  m_x, m_xv, m_fs, m_lb;
   bit    live = 1'b0;

   initial begin
      mbit_t e;
      m_x = 1'b0; m_xv = 1'b0; m_fs = 1'b0; m_lb = 1'b0;
      forever begin
         @(posedge clk);
         if (rst) begin
            mq.delete();
            m_x = 1'b0; m_xv = 1'b0; m_fs = 1'b0; m_lb = 1'b0;
            live = 1'b1;
         end else begin
            if (din_valid && (mq.size() < W)) begin
               for (int k = 0; k < W; k++) begin
                  e.b  = din[W-1-k];
                  e.fs = (k == 0);
                  e.lb = (k == W-1);
                  mq.push_back(e);
               end
            end
            if (mq.size() > 0) begin
               e = mq.pop_front();
               m_x = e.b; m_xv = 1'b1; m_fs = e.fs; m_lb = e.lb;
            end else begin
               m_x = 1'b0; m_xv = 1'b0; m_fs = 1'b0; m_lb = 1'b0;
            end
         end
      end
   end

   // Capture of the valid bit streams for the directed literal checks
   logic cap[$], cap_fs[$], cap_lb[$], cap2[$], cap2_fs[$];
   int   xv_falls = 0;
   logic prev_xv  = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (live) begin
            check("x", x, m_x);
            check("x_valid", x_valid, m_xv);
            check("frame_start", frame_start, m_fs);
            check("last_bit", last_bit, m_lb);
            check("busy", busy, m_xv || (mq.size() >= W));
            check("din_ready", din_ready, !rst && (mq.size() < W));
         end
         if (x_valid === 1'b1) begin
            cap.push_back(x); cap_fs.push_back(frame_start); cap_lb.push_back(last_bit);
         end
         if (x2_valid === 1'b1) begin
            cap2.push_back(x2); cap2_fs.push_back(fs2);
         end
         if (prev_xv && !x_valid) xv_falls++;
         prev_xv = x_valid;
      end
   end

   function automatic logic [31:0] pack(input int sel);
      logic [31:0] v;
      v = 32'h0;
      case (sel)
         0: foreach (cap[i])     v = {v[30:0], cap[i]};
         1: foreach (cap_fs[i])  v = {v[30:0], cap_fs[i]};
         2: foreach (cap_lb[i])  v = {v[30:0], cap_lb[i]};
         3: foreach (cap2[i])    v = {v[30:0], cap2[i]};
         default: foreach (cap2_fs[i]) v = {v[30:0], cap2_fs[i]};
      endcase
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_cap();
      cap.delete(); cap_fs.delete(); cap_lb.delete(); cap2.delete(); cap2_fs.delete();
      xv_falls = 0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 100) begin
         step();
         n++;
      end
      check({name, "_timeout"}, (n < 100) ? 32'd1 : 32'd0, 32'd1);
   endtask

   logic [7:0] words [3];
   int         acc_edge [3];
   logic       rdy_hist [16];
   int         widx, rdy_cnt;
   logic       win_hit;
   logic [5:0] win;

   initial begin
      rst = 1'b1; din = 8'h00; din_valid = 1'b0; din2 = 8'h00; din2_valid = 1'b0;
      repeat (3) step();
      @(negedge clk);
      check("reset_x", x, 1'b0);
      check("reset_x_valid", x_valid, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_ready", din_ready, 1'b0);
      step();
      rst = 1'b0;
      #1;
      check("ready_after_reset", din_ready, 1'b1);

      // Single word
      clear_cap();
      din = 8'hDB; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      wait_idle("single");
      check("single_len", cap.size(), 8);
      check("single_bits", pack(0), 32'h000000DB);
      check("single_fs", pack(1), 32'h00000080);
      check("single_lb", pack(2), 32'h00000001);
      check("single_idle_x", x, 1'b0);
      check("single_idle_xv", x_valid, 1'b0);

      // Back-to-back words with valid held
      clear_cap();
      din = 8'hDB; din_valid = 1'b1;
      step();
      din = 8'h6C;
      step();
      din_valid = 1'b0;
      wait_idle("b2b");
      check("b2b_len", cap.size(), 16);
      check("b2b_bits", pack(0), 32'h0000DB6C);
      check("b2b_fs", pack(1), 32'h00008080);
      check("b2b_gapless", xv_falls, 1);
      win = 6'b0; win_hit = 1'b0;
      foreach (cap[i]) begin
         win = {win[4:0], cap[i]};
         if (i >= 5 && win == 6'b110110) win_hit = 1'b1;
      end
      check("b2b_detect_110110", win_hit, 1'b1);

      // Backpressure: A, B, C with valid held
      clear_cap();
      words[0] = 8'h3C; words[1] = 8'hA9; words[2] = 8'h5E;
      widx = 0;
      din = words[0]; din_valid = 1'b1;
      for (int e = 1; e <= 14; e++) begin
         #1;
         rdy_hist[e] = din_ready;
         if (din_ready && din_valid) begin
            acc_edge[widx] = e;
            widx++;
         end
         step();
         if (widx == 3) din_valid = 1'b0;
         else din = words[widx];
      end
      wait_idle("bp");
      check("bp_accepts", widx, 3);
      check("bp_edge_A", acc_edge[0], 1);
      check("bp_edge_B", acc_edge[1], 2);
      check("bp_edge_C", acc_edge[2], 10);
      rdy_cnt = 0;
      for (int e = 3; e <= 9; e++) if (rdy_hist[e]) rdy_cnt++;
      check("bp_ready_low_3_9", rdy_cnt, 0);
      check("bp_len", cap.size(), 24);
      check("bp_bits", pack(0), 32'h003CA95E);

      // Bypass at the edge ending the last bit
      clear_cap();
      din = 8'hC3; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      repeat (7) step();
      din = 8'h96; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      wait_idle("bypass");
      check("bypass_len", cap.size(), 16);
      check("bypass_bits", pack(0), 32'h0000C396);
      check("bypass_fs", pack(1), 32'h00008080);
      check("bypass_gapless", xv_falls, 1);

      // Reset mid-word with a second word buffered
      din = 8'hFF; din_valid = 1'b1;
      step();
      din = 8'h77;
      step();
      din_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_cap();
      @(negedge clk);
      check("rst_mid_xv", x_valid, 1'b0);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_ready", din_ready, 1'b1);
      din = 8'hA5; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      wait_idle("post_rst");
      check("post_rst_len", cap.size(), 8);
      check("post_rst_bits", pack(0), 32'h000000A5);

      // LSB-first instance
      clear_cap();
      din2 = 8'h01; din2_valid = 1'b1;
      step();
      din2_valid = 1'b0;
      repeat (10) step();
      check("lsb_len", cap2.size(), 8);
      check("lsb_bits", pack(3), 32'h00000080);
      check("lsb_fs", pack(4), 32'h00000080);
      check("lsb_idle", busy2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
